// File: rtl/pipelined_dot_product.sv
// Streaming LANES-wide multiply-accumulate engine: registered lane products, a registered
// pairwise adder tree and a per-vector accumulator that emits one result per last beat.
module pipelined_dot_product #(
    parameter int WIDTH  = 32,
    parameter int LANES  = 4,
    parameter bit SIGNED = 1'b0,
    parameter int ACC_W  = 72
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    output logic [ACC_W-1:0]       out_data,
    output logic [15:0]            out_beats
);
    localparam int T  = $clog2(LANES);
    localparam int PW = 2 * WIDTH;
    localparam int SW = PW + T;

    function automatic logic [PW-1:0] ext_op(input logic [WIDTH-1:0] x);
        if (SIGNED) begin
            return {{WIDTH{x[WIDTH-1]}}, x};
        end else begin
            return {{WIDTH{1'b0}}, x};
        end
    endfunction

    logic [T:0]       r_vld;
    logic [T:0]       r_lst;
    logic [ACC_W-1:0] r_acc;
    logic [15:0]      r_cnt;
    logic             r_first;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_data;
    logic [15:0]      r_out_beats;

    logic [SW-1:0]    w_tree_out;
    logic [ACC_W-1:0] w_sum_ext;
    logic [ACC_W-1:0] w_total;
    logic [15:0]      w_beats;

    // Control shift chain; index k is aligned with data stage k (0 = products, T = tree root).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= {(T+1){1'b0}};
            r_lst <= {(T+1){1'b0}};
        end else begin
            r_vld[0] <= in_valid;
            r_lst[0] <= in_valid & in_last;
            for (int i = 1; i <= T; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_lst[i] <= r_lst[i-1];
            end
        end
    end

    genvar gl;
    generate
        for (gl = 0; gl <= T; gl++) begin : g_lvl
            localparam int LW = PW + gl;
            localparam int N  = LANES >> gl;
            logic [LW-1:0] r_node [N];
            if (gl == 0) begin : g_mul
                // Full-precision lane products; operands are extended to 2*WIDTH first.
                always_ff @(posedge clk) begin
                    for (int k = 0; k < N; k++) begin
                        r_node[k] <= ext_op(in_a[k*WIDTH +: WIDTH]) * ext_op(in_b[k*WIDTH +: WIDTH]);
                    end
                end
            end else begin : g_add
                // Pairwise sum of the previous level, grown by one bit so nothing is lost.
                always_ff @(posedge clk) begin
                    for (int k = 0; k < N; k++) begin
                        r_node[k] <= {SIGNED & g_lvl[gl-1].r_node[2*k][LW-2], g_lvl[gl-1].r_node[2*k]}
                                   + {SIGNED & g_lvl[gl-1].r_node[2*k+1][LW-2], g_lvl[gl-1].r_node[2*k+1]};
                    end
                end
            end
        end
    endgenerate

    assign w_tree_out = g_lvl[T].r_node[0];

    // Beat sum widened to the accumulator width.
    always_comb begin
        if (SIGNED) begin
            w_sum_ext = ACC_W'(signed'(w_tree_out));
        end else begin
            w_sum_ext = ACC_W'(w_tree_out);
        end
    end

    // Running total and beat count; the first beat of a vector ignores stale state.
    always_comb begin
        if (r_first) begin
            w_total = w_sum_ext;
            w_beats = 16'd1;
        end else begin
            w_total = r_acc + w_sum_ext;
            if (r_cnt == 16'hFFFF) begin
                w_beats = 16'hFFFF;
            end else begin
                w_beats = r_cnt + 16'd1;
            end
        end
    end

    // Accumulate stage: hold on bubbles, publish and re-arm on a last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= {ACC_W{1'b0}};
            r_cnt       <= 16'd0;
            r_first     <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= {ACC_W{1'b0}};
            r_out_beats <= 16'd0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_vld[T]) begin
                if (r_lst[T]) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_total;
                    r_out_beats <= w_beats;
                    r_first     <= 1'b1;
                end else begin
                    r_acc   <= w_total;
                    r_cnt   <= w_beats;
                    r_first <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_beats = r_out_beats;

endmodule

// File: doc/pipelined_dot_product.md
Name: pipelined_dot_product

Overview:
- Streaming, fully pipelined N-lane multiply-accumulate engine.
- Each valid beat presents LANES operand pairs. The block multiplies the pairs, reduces the products through a registered adder tree and accumulates the beat sums until a beat flagged last.
- It then emits one result per vector.
- Parametrised successor of the two-lane multiply/add pipeline: adds width/lane generalisation, valid qualification, multi-beat accumulation, signed mode and reset.

Parameters:
- WIDTH, 32, bit width of each operand.
- LANES, 4, operand pairs per beat; power of two, 1..16.
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands.
- ACC_W, 72, accumulator/result width; must be at least 2*WIDTH+log2(LANES).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  beat qualifier.
- in_last  input  1  beat is final beat of current vector; ignored when in_valid=0.
- in_a  input  LANES*WIDTH  operand A; lane k occupies bits [k*WIDTH +: WIDTH].
- in_b  input  LANES*WIDTH  operand B, same packing.
- out_valid  output  1  one-cycle pulse; result present.
- out_data  output  ACC_W  dot product of the completed vector.
- out_beats  output  16  number of valid beats in the completed vector.

Behaviour:
- No backpressure. The block accepts a beat every cycle in_valid=1 and never stalls.
- Pipeline, T = log2(LANES):
  - Stage M: register LANES full-precision products, 2*WIDTH bits each. Products are sign-extended if SIGNED=1, zero-extended otherwise.
  - Stages R1..RT: pairwise adder tree. Each level is registered and widens by 1 bit; no truncation anywhere in the tree.
  - Stage A: accumulate.
- in_valid and in_last travel alongside the data in a shift chain of matching depth.
- Latency: a last beat sampled at edge t produces out_valid=1 during the cycle after edge t+1+T.
  - LANES=4: 4 cycles.
  - LANES=1: 2 cycles.
- Accumulator state: acc (ACC_W), first flag (reset 1), beat count cnt (16 bits).
- At stage A with a valid beat of sum s (extended to ACC_W per SIGNED):
  - total = (first ? 0 : acc) + s, modulo 2^ACC_W; wraps, no saturation.
  - beats = (first ? 1 : cnt+1), saturating at 65535.
  - If last: out_data <= total, out_beats <= beats, out_valid <= 1, first <= 1.
  - Else: acc <= total, cnt <= beats, first <= 0.
- Invalid cycles (bubbles) between beats of one vector: acc, cnt and first hold; no output.
- out_valid is 0 on every cycle not caused by a last beat.
- out_data and out_beats hold their last values between results.
- Back-to-back single-beat vectors (in_last=1 every cycle) yield one result per cycle. There is no carry-over between vectors.
- Reset (synchronous), all outputs and state:
  - out_valid=0, out_data=0, out_beats=0.
  - All pipeline valid/last bits=0, acc=0, cnt=0, first=1.
  - Data pipeline registers may also be cleared.
- Reset mid-operation discards every in-flight beat and any partial accumulation. No out_valid from pre-reset beats ever appears.
- A beat sampled on the cycle rst=1 is dropped.

Test Plan:
- Single beat, defaults: a=(1,2,3,4), b=(5,6,7,8), in_last=1 at edge 0 -> out_valid exactly at cycle 4, out_data=70, out_beats=1.
- Three-beat vector with bubbles: beats (1,2,3,4)x(5,6,7,8), two idle cycles, same beat again, then a=(1,1,1,1) b=(1,2,3,4) last -> single out_valid pulse, out_data=150, out_beats=3.
- Back-to-back: 8 consecutive single-beat vectors with a=(k,0,0,0), b=(1,0,0,0), k=1..8 -> out_valid high 8 consecutive cycles, out_data=1..8 in order.
- SIGNED=1, WIDTH=8: a=(-1,-2,0,0), b=(3,4,0,0), last -> out_data=-11 sign-extended to ACC_W.
- SIGNED=0, WIDTH=8, all lanes a=b=255, last -> out_data=260100, no truncation.
- Reset mid-vector: two non-last beats, rst for 1 cycle with a beat on the rst cycle, then a=(1,2,3,4) b=(1,1,1,1) last -> exactly one out_valid, out_data=10, out_beats=1; out_valid=0 throughout and after reset until then.
